fetch_inst_queue: RTL

FETCH_INST_QUEUE -- requirements
Module: fetch_inst_queue

---
 rtl/fetch_inst_queue_pkg.sv | 16 +
 rtl/fetch_inst_queue_ram.sv | 43 ++++
 rtl/fetch_inst_queue.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_inst_queue_pkg.sv
// Shared fetch/decode pipeline types for the instruction queue.
// Entry layout and width constants used by the queue and its storage.
package fetch_inst_queue_pkg;

    localparam int unsigned IQ_DEPTH = 8;
    localparam int unsigned PC_W     = 64;
    localparam int unsigned INST_W   = 32;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } iq_entry_t;

    localparam int unsigned ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/fetch_inst_queue_ram.sv
// Two-write / two-read register file backing the fetch instruction queue.
// Reads are asynchronous so the decoder sees the head with no added latency.
module inst_queue_ram
    import fetch_inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we0_i,
    input  logic [AW-1:0]   waddr0_i,
    input  iq_entry_t       wdata0_i,
    input  logic            we1_i,
    input  logic [AW-1:0]   waddr1_i,
    input  iq_entry_t       wdata1_i,
    input  logic [AW-1:0]   raddr0_i,
    output iq_entry_t       rdata0_o,
    input  logic [AW-1:0]   raddr1_i,
    output iq_entry_t       rdata1_o
);

    iq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (we0_i) begin
                mem_q[waddr0_i] <= wdata0_i;
            end
            if (we1_i) begin
                mem_q[waddr1_i] <= wdata1_i;
            end
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer taking up to two
// instructions per cycle from fetch and presenting up to two to decode.
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              fetch_inst0_valid_i,
    input  logic [PC_W-1:0]   fetch_inst0_pc_i,
    input  logic [INST_W-1:0] fetch_inst0_inst_i,
    input  logic              fetch_inst1_valid_i,
    input  logic [PC_W-1:0]   fetch_inst1_pc_i,
    input  logic [INST_W-1:0] fetch_inst1_inst_i,
    output logic              fetch_ready_o,
    input  logic              stall_decoder_inst0_i,
    input  logic              stall_decoder_inst1_i,
    output logic              inst0_f1_valid_o,
    output logic [PC_W-1:0]   inst0_f1_pc_o,
    output logic [INST_W-1:0] inst0_f1_inst_o,
    output logic              inst1_f1_valid_o,
    output logic [PC_W-1:0]   inst1_f1_pc_o,
    output logic [INST_W-1:0] inst1_f1_inst_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [CW-1:0] free_slots;
    logic [AW-1:0] wr_ptr_p1;
    logic [AW-1:0] rd_ptr_p1;
    logic          enq0, enq1;
    logic          deq_en;
    logic [1:0]    enq_cnt, deq_cnt;

    iq_entry_t     wdata0, wdata1;
    iq_entry_t     rdata0, rdata1;

    assign free_slots = DEPTH_C - count_q;
    assign fetch_ready_o = (free_slots >= TWO_C) && !flush_i;

    // Slot 1 is only taken behind a valid slot 0 so order stays contiguous.
    assign enq0 = fetch_ready_o && fetch_inst0_valid_i;
    assign enq1 = enq0 && fetch_inst1_valid_i;
    assign enq_cnt = {1'b0, enq0} + {1'b0, enq1};

    assign inst0_f1_valid_o = (count_q != '0) && !flush_i;
    assign inst1_f1_valid_o = (count_q >= TWO_C) && !flush_i;

    assign deq_en  = !stall_decoder_inst0_i && !stall_decoder_inst1_i;
    assign deq_cnt = deq_en
                   ? ({1'b0, inst0_f1_valid_o} + {1'b0, inst1_f1_valid_o})
                   : 2'd0;

    assign wr_ptr_p1 = wr_ptr_q + AW'(1);
    assign rd_ptr_p1 = rd_ptr_q + AW'(1);

    assign wdata0 = '{pc: fetch_inst0_pc_i, inst: fetch_inst0_inst_i};
    assign wdata1 = '{pc: fetch_inst1_pc_i, inst: fetch_inst1_inst_i};

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .we0_i    (enq0),
        .waddr0_i (wr_ptr_q),
        .wdata0_i (wdata0),
        .we1_i    (enq1),
        .waddr1_i (wr_ptr_p1),
        .wdata1_i (wdata1),
        .raddr0_i (rd_ptr_q),
        .rdata0_o (rdata0),
        .raddr1_i (rd_ptr_p1),
        .rdata1_o (rdata1)
    );

    assign inst0_f1_pc_o   = inst0_f1_valid_o ? rdata0.pc   : '0;
    assign inst0_f1_inst_o = inst0_f1_valid_o ? rdata0.inst : '0;
    assign inst1_f1_pc_o   = inst1_f1_valid_o ? rdata1.pc   : '0;
    assign inst1_f1_inst_o = inst1_f1_valid_o ? rdata1.inst : '0;

    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(deq_cnt);
        wr_ptr_d = wr_ptr_q + AW'(enq_cnt);
        count_d  = count_q + CW'(enq_cnt) - CW'(deq_cnt);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
